// File: rtl/weight_row_fetch_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | weight_row_fetch_if : start/status, SRAM read port and weight row stream   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
interface weight_row_fetch_if #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 512,
   parameter int CNT_W  = 7
);
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [CNT_W-1:0]  num_rows;
   logic              busy;
   logic              done;
   logic              sram_csb;
   logic              sram_wsb;
   logic [ADDR_W-1:0] sram_raddr;
   logic [DATA_W-1:0] sram_rdata;
   logic              w_valid;
   logic              w_ready;
   logic [DATA_W-1:0] w_data;
   logic              w_last;

   modport master (
      input  start, base_addr, num_rows, sram_rdata, w_ready,
      output busy, done, sram_csb, sram_wsb, sram_raddr, w_valid, w_data, w_last
   );

   modport slave (
      output start, base_addr, num_rows, sram_rdata, w_ready,
      input  busy, done, sram_csb, sram_wsb, sram_raddr, w_valid, w_data, w_last
   );
endinterface
`default_nettype wire

// File: rtl/weight_row_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | weight_row_fetch : reads N weight-SRAM rows into a 2-entry FIFO and streams |
// | them out over valid/ready.                            Revision 1.0          |
// +----------------------------------------------------------------------------+
module weight_row_fetch #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 512,
   parameter int CNT_W  = 7
) (
   input  wire logic           clk,
   input  wire logic           rst,
   weight_row_fetch_if.master  bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_addr;
   logic [CNT_W-1:0]  r_remain;
   logic              r_busy;
   logic              r_done;
   logic              r_inflight;
   logic              r_inflight_last;
   logic [DATA_W-1:0] r_fifo_data [2];
   logic [1:0]        r_fifo_last;
   logic              r_wptr;
   logic              r_rptr;
   logic [1:0]        r_cnt;

   logic              w_valid;
   logic              w_pop;
   logic              w_push;
   logic [2:0]        w_occ;
   logic              w_issue;
   logic              w_last_issue;
   logic              w_drained;

   // Occupancy counts FIFO entries plus the read still in the SRAM pipe,
   // net of this cycle's pop, so a full FIFO can still issue when it drains.
   assign w_valid      = (r_cnt != 2'd0);
   assign w_pop        = w_valid & bus.w_ready;
   assign w_push       = r_inflight;
   assign w_occ        = {1'b0, r_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
   assign w_issue      = (r_state == S_FETCH) && (r_remain != '0) && (w_occ < 3'd2);
   assign w_last_issue = w_issue && (r_remain == CNT_W'(1));
   assign w_drained    = !r_inflight && ((r_cnt == 2'd0) || ((r_cnt == 2'd1) && w_pop));

   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
   assign bus.sram_csb   = ~w_issue;
   assign bus.sram_wsb   = 1'b1;
   assign bus.sram_raddr = w_issue ? r_addr : '0;
   assign bus.w_valid    = w_valid;
   assign bus.w_data     = r_fifo_data[r_rptr];
   assign bus.w_last     = w_valid & r_fifo_last[r_rptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_addr   <= '0;
         r_remain <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_addr   <= bus.base_addr;
                  r_remain <= bus.num_rows;
                  if (bus.num_rows == '0) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= S_FETCH;
                     r_busy  <= 1'b1;
                  end
               end
            end
            S_FETCH: begin
               if (w_issue) begin
                  r_addr   <= r_addr + ADDR_W'(1);
                  r_remain <= r_remain - CNT_W'(1);
                  if (w_last_issue) begin
                     r_state <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               if (w_drained) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_inflight      <= 1'b0;
         r_inflight_last <= 1'b0;
      end else begin
         r_inflight      <= w_issue;
         r_inflight_last <= w_last_issue;
      end
   end

   // Returning SRAM data lands here one cycle after issue, tagged with its last flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fifo_data[0] <= '0;
         r_fifo_data[1] <= '0;
         r_fifo_last    <= 2'b00;
         r_wptr         <= 1'b0;
         r_rptr         <= 1'b0;
         r_cnt          <= 2'd0;
      end else begin
         if (w_push) begin
            r_fifo_data[r_wptr] <= bus.sram_rdata;
            r_fifo_last[r_wptr] <= r_inflight_last;
            r_wptr              <= ~r_wptr;
         end
         if (w_pop) begin
            r_rptr <= ~r_rptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 2'd1;
            2'b01:   r_cnt <= r_cnt - 2'd1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_weight_row_fetch.sv
`default_nettype none
// Testbench for weight_row_fetch: table of directed transfers plus reset-in-flight sequence.
module tb_weight_row_fetch;

   localparam int ADDR_W = 6;
   localparam int DATA_W = 512;
   localparam int CNT_W  = 7;

   typedef struct {
      int base;
      int num;
      int toggle;          // 1: w_ready = 1,0,1,0... from the start cycle
      int restart_cyc;     // cycle of a second start pulse, -1 for none
      int pre_reset;       // 1: abort a 6-row transfer with rst first
      int exp_first_valid; // -1: w_valid never expected
      int exp_last_beat;
      int exp_done;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   weight_row_fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

   weight_row_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic logic [DATA_W-1:0] row_of(input int a);
      logic [DATA_W-1:0] r;
      logic [5:0] av;
      logic [4:0] jv;
      r  = '0;
      av = a[5:0];
      for (int j = 0; j < 32; j++) begin
         jv = j[4:0];
         r[j*16 +: 16] = {av, jv, 5'h15};
      end
      return r;
   endfunction

   always @(posedge clk) begin
      if (!bus.sram_csb) bus.sram_rdata <= row_of(int'(bus.sram_raddr));
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string pfx);
      chk({pfx, "_busy"},     int'(bus.busy), 0);
      chk({pfx, "_done"},     int'(bus.done), 0);
      chk({pfx, "_csb"},      int'(bus.sram_csb), 1);
      chk({pfx, "_wsb"},      int'(bus.sram_wsb), 1);
      chk({pfx, "_raddr"},    int'(bus.sram_raddr), 0);
      chk({pfx, "_w_valid"},  int'(bus.w_valid), 0);
      chk({pfx, "_w_data0"},  int'(bus.w_data == '0), 1);
      chk({pfx, "_w_last"},   int'(bus.w_last), 0);
   endtask

   task automatic mid_reset();
      int pops = 0;
      @(posedge clk); #1;
      bus.start = 1'b1; bus.base_addr = ADDR_W'(20); bus.num_rows = CNT_W'(6);
      bus.w_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (c > 0) begin @(posedge clk); #1; bus.start = 1'b0; end
         @(negedge clk);
         if (bus.w_valid && bus.w_ready) pops++;
         if (pops == 2) break;
      end
      chk("midrst_two_rows_before_reset", pops, 2);
      chk("midrst_reading_before_reset", int'(bus.sram_csb), 0);
      #2 rst = 1'b1;
      #1 chk_reset_outputs("midrst");
      @(posedge clk); #1;
      chk_reset_outputs("midrst_held");
      rst = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int first_valid = -1, last_beat = -1, done_cyc = -1, done_cnt = 0;
      int issues = 0, pops = 0, max_out = 0, busy1 = -1, busy_at_done = -1;
      int addr_err = 0, data_err = 0, last_err = 0, hold_err = 0, wsb_err = 0;
      int exp_addr;
      logic prev_stall = 1'b0;
      logic [DATA_W-1:0] prev_data = '0;
      string p;
      p = $sformatf("v%0d", idx);

      @(posedge clk); #1;
      bus.start = 1'b1; bus.base_addr = ADDR_W'(v.base); bus.num_rows = CNT_W'(v.num);
      for (int c = 0; c < 120; c++) begin
         if (c > 0) begin
            @(posedge clk); #1;
            bus.start = (c == v.restart_cyc);
            if (c == v.restart_cyc) begin
               bus.base_addr = ADDR_W'(40); bus.num_rows = CNT_W'(3);
            end
         end
         bus.w_ready = (v.toggle != 0) ? ((c % 2) == 0) : 1'b1;
         @(negedge clk);
         if (!bus.sram_csb) begin
            exp_addr = (v.base + issues) % 64;
            if (int'(bus.sram_raddr) != exp_addr) begin
               if (addr_err == 0)
                  $display("  %s read %0d raddr=%0d want %0d", p, issues, bus.sram_raddr, exp_addr);
               addr_err++;
            end
            issues++;
         end
         if (bus.w_valid) begin
            if (first_valid < 0) first_valid = c;
            if (prev_stall && (bus.w_data !== prev_data)) hold_err++;
            if (bus.w_ready) begin
               if (bus.w_data !== row_of((v.base + pops) % 64)) data_err++;
               if (bus.w_last !== (pops == v.num - 1)) last_err++;
               pops++;
               last_beat = c;
            end
         end else if (prev_stall) begin
            hold_err++;
         end
         prev_stall = bus.w_valid & ~bus.w_ready;
         prev_data  = bus.w_data;
         if (issues - pops > max_out) max_out = issues - pops;
         if (c == 1) busy1 = int'(bus.busy);
         if (bus.sram_wsb !== 1'b1) wsb_err++;
         if (bus.done) begin
            done_cnt++;
            if (done_cyc < 0) begin done_cyc = c; busy_at_done = int'(bus.busy); end
         end
         if (done_cyc >= 0 && c >= done_cyc + 3) break;
      end
      bus.start = 1'b0;

      chk({p, "_reads_issued"},    issues, v.num);
      chk({p, "_raddr_errors"},    addr_err, 0);
      chk({p, "_beats"},           pops, v.num);
      chk({p, "_data_errors"},     data_err, 0);
      chk({p, "_last_errors"},     last_err, 0);
      chk({p, "_stall_hold_err"},  hold_err, 0);
      chk({p, "_first_valid_cyc"}, first_valid, v.exp_first_valid);
      chk({p, "_last_beat_cyc"},   last_beat, v.exp_last_beat);
      chk({p, "_done_cyc"},        done_cyc, v.exp_done);
      chk({p, "_done_pulses"},     done_cnt, 1);
      chk({p, "_outstanding_le2"}, int'(max_out <= 2), 1);
      chk({p, "_busy_cyc1"},       busy1, int'(v.num != 0));
      chk({p, "_busy_at_done"},    busy_at_done, 0);
      chk({p, "_wsb_errors"},      wsb_err, 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs [8];
      vecs[0] = '{0,  4,  0, -1, 0,  3,  6,  7};
      vecs[1] = '{62, 4,  0, -1, 0,  3,  6,  7};
      vecs[2] = '{5,  8,  1, -1, 0,  3, 18, 19};
      vecs[3] = '{7,  0,  0, -1, 0, -1, -1,  1};
      vecs[4] = '{30, 6,  0,  2, 0,  3,  8,  9};
      vecs[5] = '{0,  4,  0,  7, 0,  3,  6,  7};
      vecs[6] = '{63, 64, 0, -1, 0,  3, 66, 67};
      vecs[7] = '{10, 1,  0, -1, 1,  3,  3,  4};

      bus.start = 1'b0; bus.base_addr = '0; bus.num_rows = '0;
      bus.w_ready = 1'b0; bus.sram_rdata = '0;
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      chk_reset_outputs("por");
      @(posedge clk); #1 rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         if (vecs[i].pre_reset != 0) mid_reset();
         run_vec(vecs[i], i);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
